dac7611_scheduler: RTL and testbench
====================================

DAC7611_SCHEDULER -- requirements
Module: dac7611_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one DAC7611 (range 2..4).
REQ-002 Parameter GAP_CYC, default 4, idle clk_X4 cycles between transfers (range 1..15).
REQ-003 clk_X4  input  1  sole clock; 4x the DAC serial clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 enable  input  1  high enables new grants.
REQ-006 req_valid  input  NUM_REQ  per-requester code-pending flag.
REQ-007 req_data  input  12*NUM_REQ  requester i code at bits [12i+11:12i].
REQ-008 req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 grant_id  output  2  index of the requester most recently granted.
REQ-010 busy  output  1  high from the cycle after a grant until the return to IDLE.
REQ-011 done  output  1  one-cycle pulse on the last GAP cycle.
REQ-012 dac_clk, dac_sdi, dac_cs_n, dac_ld_n  output  1 each  DAC7611 CLK, SDI, CS and LD pins.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, LOAD and GAP, advanced by a 6-bit phase counter cnt.
REQ-014 In IDLE with enable=1 and any req_valid set, the block SHALL grant one requester, pulse its req_ready, latch its 12-bit code and grant_id, clear cnt and enter SHIFT on the next cycle.
REQ-015 req_valid and req_data SHALL be sampled only in the grant cycle; a requester SHALL hold req_valid until it sees req_ready.
REQ-016 SHIFT SHALL last 48 cycles (cnt 0..47), with dac_cs_n=0.
REQ-017 In SHIFT, dac_sdi SHALL equal latched code bit (11 - cnt[5:2]), so the MSB goes first.
REQ-018 In SHIFT, dac_clk SHALL be 0 when cnt[1]=0 and 1 when cnt[1]=1, so each bit is stable 2 cycles before the rising edge.
REQ-019 LOAD SHALL last 4 cycles: dac_cs_n=1, dac_clk=1, dac_ld_n=0, dac_sdi=0.
REQ-020 GAP SHALL last GAP_CYC cycles with all pins at their idle levels, then return to IDLE.
REQ-021 Pin idle levels SHALL be: dac_clk=1, dac_sdi=0, dac_cs_n=1, dac_ld_n=1.
REQ-022 One transfer SHALL take exactly 1+48+4+GAP_CYC cycles from grant to the next possible grant (57 at default).
REQ-023 If enable goes low mid-transfer, the transfer SHALL complete; no new grant SHALL occur while enable=0.
REQ-024 A req_valid asserted for a requester during a transfer SHALL wait; it is granted in the first IDLE cycle by arbitration.
REQ-025 req_ready SHALL never be asserted outside IDLE, and never for more than one requester per cycle.

Reset
REQ-026 With rst_n=0, the block SHALL immediately enter IDLE, at any time including mid-SHIFT or mid-LOAD.
REQ-027 Reset values SHALL be: cnt=0, the round-robin pointer=0, req_ready=0, grant_id=0, busy=0, done=0, and all pins at their idle levels.
REQ-028 An aborted transfer SHALL NOT pulse dac_ld_n.

Configuration
REQ-029 With DAC_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest index wins.
REQ-030 Without DAC_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin: the search starts at the pointer, and the pointer becomes (winner+1) mod NUM_REQ after each grant.

Structure
REQ-031 A shared package dac7611_pkg SHALL hold:
- the state enum;
- DAC_BITS=12;
- SHIFT_CYC=48;
- LOAD_CYC=4;
- the pin idle-level constants.
REQ-032 The arbiter SHALL be a sub-module dac_rr_arbiter: req vector in; one-hot grant and index out; pointer inside; fixed-priority mode under the macro.

Verification
REQ-033 Reset, then requester 0 valid with code 12'hA5C -> req_ready[0] pulses once; dac_sdi across the 12 dac_clk rising edges reads 1010_0101_1100; dac_ld_n is low for 4 cycles; done fires 56 cycles after the grant.
REQ-034 Both requesters valid continuously, round-robin build -> grants alternate 0,1,0,1 with 57 cycles between consecutive req_ready pulses.
REQ-035 Same stimulus, DAC_SCHED_FIXED_PRIO_EN build -> requester 0 is granted every time and requester 1 never.
REQ-036 rst_n pulsed low at cnt=20 of SHIFT -> pins go to idle levels asynchronously, dac_ld_n never falls, and the next grant restarts at the MSB.
REQ-037 enable dropped at cnt=10 with requester 1 pending -> the current transfer completes with its LD pulse, then no grant occurs until enable=1.
REQ-038 Codes 12'h000 and 12'hFFF -> dac_sdi is constant 0 or 1 throughout SHIFT, and dac_clk still shows 12 rising edges.

Source files
------------

// File: rtl/dac7611_pkg.sv
// dac7611_pkg
// Shared definitions for the DAC7611 transfer scheduler:
//   - FSM state enum
//   - frame geometry (DAC_BITS, SHIFT_CYC, LOAD_CYC, counter width)
//   - DAC pin bundle type and the pin idle levels
//   - pins_for(): maps a (state, cnt, code) triple onto the four DAC pins
package dac7611_pkg;

  localparam int DAC_BITS  = 12;
  localparam int SHIFT_CYC = 48;   // 12 bits x 4 clk_X4 cycles per DAC clock
  localparam int LOAD_CYC  = 4;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic clk;
    logic sdi;
    logic cs_n;
    logic ld_n;
  } dac_pins_t;

  localparam logic IDLE_CLK  = 1'b1;
  localparam logic IDLE_SDI  = 1'b0;
  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_LD_N = 1'b1;

  localparam dac_pins_t PINS_IDLE = '{clk: IDLE_CLK, sdi: IDLE_SDI,
                                      cs_n: IDLE_CS_N, ld_n: IDLE_LD_N};

  // During SHIFT, cnt[5:2] selects the bit (MSB first) and cnt[1] is the
  // DAC clock, so each bit sits on SDI for two cycles before the rising edge.
  function automatic dac_pins_t pins_for(input state_e             st,
                                         input logic [CNT_W-1:0]   cnt,
                                         input logic [DAC_BITS-1:0] code);
    dac_pins_t p;
    p = PINS_IDLE;
    case (st)
      ST_SHIFT: begin
        p.clk  = cnt[1];
        p.sdi  = code[4'(DAC_BITS-1) - cnt[5:2]];
        p.cs_n = 1'b0;
        p.ld_n = 1'b1;
      end
      ST_LOAD: begin
        p.clk  = 1'b1;
        p.sdi  = 1'b0;
        p.cs_n = 1'b1;
        p.ld_n = 1'b0;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dac7611_scheduler_arbiter.sv
// dac_rr_arbiter
// Picks one requester out of NUM_REQ (2..4).
// Default build: round-robin, search starts at an internal pointer which
// moves to (winner+1) mod NUM_REQ whenever a grant is taken.
// With DAC_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
// Ports:
//   clk_X4, rst_n : clock, async active-low reset (pointer only)
//   req_i         : request vector
//   advance_i     : the current pick is actually being granted this cycle
//   gnt_o         : one-hot pick (zero when no request)
//   idx_o         : index of the pick
//   valid_o       : at least one request present
module dac_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_X4,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         idx_o,
  output logic               valid_o
);

`ifdef DAC_SCHED_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk_X4, rst_n, advance_i};

  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (!found && req_i[c]) begin
        found = 1'b1;
        idx_o = 2'(c);
      end
    end
    valid_o = found;
  end

`else

  logic [1:0] ptr_q;

  // Offset k walks away from the pointer; the second term covers wrap-around
  // without needing a modulo.
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!found && req_i[c] &&
            ((int'(ptr_q) + k == c) || (int'(ptr_q) + k == c + NUM_REQ))) begin
          found = 1'b1;
          idx_o = 2'(c);
        end
      end
    end
    valid_o = found;
  end

  always_ff @(posedge clk_X4 or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i && valid_o) begin
      ptr_q <= (idx_o == 2'(NUM_REQ-1)) ? 2'd0 : idx_o + 2'd1;
    end
  end

`endif

  always_comb begin
    gnt_o = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      gnt_o[c] = valid_o && (idx_o == 2'(c));
    end
  end

endmodule

// File: rtl/dac7611_scheduler.sv
// dac7611_scheduler
// Shares one DAC7611 between NUM_REQ requesters. A grant latches the
// requester's 12-bit code, shifts it out MSB first, pulses LD, then waits
// GAP_CYC idle cycles before the next grant is possible.
// Build option: DAC_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
// (lowest index wins) instead of round-robin.
// Ports:
//   clk_X4     : sole clock, 4x the DAC serial clock
//   rst_n      : async active-low reset
//   enable     : allows new grants (a running transfer always completes)
//   req_valid  : per-requester code pending
//   req_data   : requester i code at [12i+11:12i]
//   req_ready  : one-cycle accept pulse to the granted requester (IDLE only)
//   grant_id   : index of the most recently granted requester
//   busy       : high from the cycle after a grant until back in IDLE
//   done       : one-cycle pulse on the last GAP cycle
//   dac_clk, dac_sdi, dac_cs_n, dac_ld_n : DAC7611 pins
//
// state  | meaning
// IDLE   | pins idle, grant when enable and a request is pending
// SHIFT  | CS low, 48 cycles clocking out 12 bits MSB first
// LOAD   | CS high, LD low for 4 cycles
// GAP    | pins idle for GAP_CYC cycles, done on the last one
module dac7611_scheduler
  import dac7611_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GAP_CYC = 4
) (
  input  logic                        clk_X4,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [DAC_BITS*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [1:0]                  grant_id,
  output logic                        busy,
  output logic                        done,
  output logic                        dac_clk,
  output logic                        dac_sdi,
  output logic                        dac_cs_n,
  output logic                        dac_ld_n
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DAC_BITS-1:0]   code_q, code_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  dac_pins_t             pins_q, pins_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [1:0]            arb_idx;
  logic                  arb_valid;
  logic                  grant_ok;
  logic [DAC_BITS-1:0]   sel_code;

  assign grant_ok = (state_q == ST_IDLE) && enable && arb_valid;

  dac_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_X4    (clk_X4),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (grant_ok),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  // Combinational so the accept pulse lands in the grant cycle itself,
  // which is the only cycle in which req_valid/req_data are sampled.
  assign req_ready = grant_ok ? arb_gnt : '0;

  always_comb begin
    sel_code = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (arb_idx == 2'(c)) sel_code = req_data[c*DAC_BITS +: DAC_BITS];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          code_d     = sel_code;
          grant_id_d = arb_idx;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values: glitch-free pins
  // with the same cycle alignment as decoding the current state.
  always_comb begin
    pins_d = pins_for(state_d, cnt_d, code_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk_X4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pins_q     <= PINS_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pins_q     <= pins_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dac_clk  = pins_q.clk;
  assign dac_sdi  = pins_q.sdi;
  assign dac_cs_n = pins_q.cs_n;
  assign dac_ld_n = pins_q.ld_n;

endmodule

// File: tb/tb_dac7611_scheduler.sv
module tb_dac7611_scheduler;

  localparam int NUM_REQ  = 2;
  localparam int GAP_CYC  = 4;
  localparam int XFER     = 1 + 48 + 4 + GAP_CYC;
  localparam int DONE_OFF = XFER - 1;

  logic        clk_X4 = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy, done, dac_clk, dac_sdi, dac_cs_n, dac_ld_n;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  logic [11:0] codes [2];

  typedef struct {
    logic [11:0] word;
    logic [1:0]  gid;
    int edges, ld_low, done_off, done_cnt, end_off, ready_bad, sdi_ones, cs_low;
  } obs_t;

  dac7611_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC)) dut (
    .clk_X4(clk_X4), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .done(done),
    .dac_clk(dac_clk), .dac_sdi(dac_sdi), .dac_cs_n(dac_cs_n), .dac_ld_n(dac_ld_n)
  );

  always #5 clk_X4 = ~clk_X4;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Reference arbitration from the rules: fixed = lowest set index,
  // round-robin = first set index scanning upward from the pointer.
  function automatic int model_pick(input logic [1:0] mask, input int ptr);
`ifdef DAC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (mask[i]) return i;
`else
    for (int k = 0; k < NUM_REQ; k++) if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic set_code(input int r, input logic [11:0] c);
    codes[r] = c;
    req_data[r*12 +: 12] = c;
  endtask

  // Follows one transfer from its grant cycle (offset 0, called #1 after that
  // negedge) until busy drops; samples first, then applies any stimulus.
  task automatic observe(input logic [1:0] clr_mask, input logic [1:0] add_mask,
                         input int add_at, input int en_off_at, output obs_t o);
    logic prev_clk;
    prev_clk = dac_clk;
    o.word = '0; o.gid = '0; o.edges = 0; o.ld_low = 0; o.done_off = -1; o.done_cnt = 0;
    o.end_off = -1; o.ready_bad = 0; o.sdi_ones = 0; o.cs_low = 0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk_X4);
      if (t == 1) o.gid = grant_id;
      if (!dac_cs_n) begin
        o.cs_low++;
        if (dac_sdi) o.sdi_ones++;
        if (dac_clk && !prev_clk) begin
          o.edges++;
          o.word = {o.word[10:0], dac_sdi};
        end
      end
      if (!dac_ld_n) o.ld_low++;
      if (done) begin
        o.done_cnt++;
        if (o.done_off < 0) o.done_off = t;
      end
      if (busy && req_ready != 2'b00) o.ready_bad++;
      prev_clk = dac_clk;
      if (t == 1) req_valid = req_valid & ~clr_mask;
      if (t == add_at) req_valid = req_valid | add_mask;
      if (t == en_off_at) enable = 1'b0;
      if (!busy) begin
        o.end_off = t;
        break;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    enable = 1'b0;
    repeat (3) @(negedge clk_X4);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if ({dac_clk, dac_sdi, dac_cs_n, dac_ld_n} !== 4'b1011) begin n_errors++; $display("FAIL reset_pins got %b exp 1011", {dac_clk, dac_sdi, dac_cs_n, dac_ld_n}); end
    n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
    repeat (2) @(negedge clk_X4);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk_X4);
    n_checks++; if ({busy, done, req_ready} !== 4'b0000) begin n_errors++; $display("FAIL post_reset_idle got %b exp 0000", {busy, done, req_ready}); end
    n_checks++; if ({dac_clk, dac_sdi, dac_cs_n, dac_ld_n} !== 4'b1011) begin n_errors++; $display("FAIL post_reset_pins got %b exp 1011", {dac_clk, dac_sdi, dac_cs_n, dac_ld_n}); end
  endtask

  task automatic test_single();
    obs_t o;
    @(negedge clk_X4);
    enable = 1'b1;
    set_code(0, 12'hA5C);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    observe(2'b01, 2'b00, -1, -1, o);
    m_ptr = 1;
    n_checks++; if (o.gid !== 2'd0) begin n_errors++; $display("FAIL single_gid got %0d exp 0", o.gid); end
    n_checks++; if (o.word !== 12'hA5C) begin n_errors++; $display("FAIL single_word got %h exp a5c", o.word); end
    n_checks++; if (o.edges != 12) begin n_errors++; $display("FAIL single_edges got %0d exp 12", o.edges); end
    n_checks++; if (o.cs_low != 48) begin n_errors++; $display("FAIL single_cs_low got %0d exp 48", o.cs_low); end
    n_checks++; if (o.ld_low != 4) begin n_errors++; $display("FAIL single_ld_low got %0d exp 4", o.ld_low); end
    n_checks++; if (o.done_off != DONE_OFF || o.done_cnt != 1) begin n_errors++; $display("FAIL single_done got off %0d cnt %0d exp off %0d cnt 1", o.done_off, o.done_cnt, DONE_OFF); end
    n_checks++; if (o.end_off != XFER) begin n_errors++; $display("FAIL single_length got %0d exp %0d", o.end_off, XFER); end
    n_checks++; if (o.ready_bad != 0) begin n_errors++; $display("FAIL single_ready_busy got %0d exp 0", o.ready_bad); end
  endtask

  task automatic test_extremes();
    obs_t o;
    logic [11:0] cv;
    int r, exp_r;
    for (int i = 0; i < 2; i++) begin
      cv = (i == 0) ? 12'h000 : 12'hFFF;
      r = $urandom_range(0, 1);
      set_code(r, cv);
      req_valid = 2'(1 << r);
      #1;
      exp_r = model_pick(req_valid, m_ptr);
      n_checks++; if (req_ready !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL ext_ready got %b exp %b", req_ready, 2'(1 << exp_r)); end
      observe(2'(1 << r), 2'b00, -1, -1, o);
      m_ptr = (exp_r + 1) % NUM_REQ;
      n_checks++; if (o.word !== cv) begin n_errors++; $display("FAIL ext_word got %h exp %h", o.word, cv); end
      n_checks++; if (o.sdi_ones != ((i == 0) ? 0 : 48)) begin n_errors++; $display("FAIL ext_sdi_const got %0d exp %0d", o.sdi_ones, (i == 0) ? 0 : 48); end
      n_checks++; if (o.edges != 12) begin n_errors++; $display("FAIL ext_edges got %0d exp 12", o.edges); end
      n_checks++; if (o.ld_low != 4) begin n_errors++; $display("FAIL ext_ld_low got %0d exp 4", o.ld_low); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0] pending, mask, add;
    int exp_r;
    pending = 2'b00;
    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < NUM_REQ; c++) if (!pending[c]) set_code(c, 12'($urandom));
      mask = pending | 2'($urandom_range(0, 3));
      if (mask == 2'b00) mask = 2'(1 << $urandom_range(0, 1));
      req_valid = mask;
      #1;
      exp_r = model_pick(mask, m_ptr);
      n_checks++; if (req_ready !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL rand_ready it %0d got %b exp %b", it, req_ready, 2'(1 << exp_r)); end
      add = 2'($urandom_range(0, 3)) & ~mask;
      observe(2'(1 << exp_r), add, $urandom_range(2, 55), -1, o);
      m_ptr = (exp_r + 1) % NUM_REQ;
      pending = (mask & ~2'(1 << exp_r)) | add;
      n_checks++; if (o.gid !== 2'(exp_r)) begin n_errors++; $display("FAIL rand_gid it %0d got %0d exp %0d", it, o.gid, exp_r); end
      n_checks++; if (o.word !== codes[exp_r]) begin n_errors++; $display("FAIL rand_word it %0d got %h exp %h", it, o.word, codes[exp_r]); end
      n_checks++; if (o.end_off != XFER || o.ld_low != 4 || o.ready_bad != 0) begin n_errors++; $display("FAIL rand_frame it %0d got len %0d ld %0d rb %0d exp %0d 4 0", it, o.end_off, o.ld_low, o.ready_bad, XFER); end
    end
  endtask

  task automatic test_back_to_back();
    int gap, exp_r;
    logic [1:0] seen;
    do_reset();
    set_code(0, 12'h123);
    set_code(1, 12'hBCD);
    req_valid = 2'b11;
    enable = 1'b1;
    #1;
    gap = 0;
    for (int g = 0; g < 4; g++) begin
      while (req_ready == 2'b00 && gap < 200) begin
        @(negedge clk_X4);
        #1;
        gap++;
      end
      seen = req_ready;
      exp_r = model_pick(2'b11, m_ptr);
      m_ptr = (exp_r + 1) % NUM_REQ;
      n_checks++; if (seen !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL b2b_grant %0d got %b exp %b", g, seen, 2'(1 << exp_r)); end
      if (g > 0) begin
        n_checks++; if (gap != XFER) begin n_errors++; $display("FAIL b2b_spacing %0d got %0d exp %0d", g, gap, XFER); end
      end
      @(negedge clk_X4);
      #1;
      gap = 1;
    end
    do_reset();
  endtask

  task automatic test_abort();
    obs_t o;
    int ld_low, r, exp_r;
    logic [11:0] cb;
    enable = 1'b1;
    set_code(0, 12'($urandom));
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL abort_ready got %b exp 01", req_ready); end
    ld_low = 0;
    for (int t = 1; t <= 21; t++) begin
      @(negedge clk_X4);
      if (!dac_ld_n) ld_low++;
      if (t == 1) req_valid = 2'b00;
    end
    n_checks++; if (dac_cs_n !== 1'b0) begin n_errors++; $display("FAIL abort_in_shift got cs_n %b exp 0", dac_cs_n); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({dac_clk, dac_sdi, dac_cs_n, dac_ld_n} !== 4'b1011) begin n_errors++; $display("FAIL abort_pins got %b exp 1011", {dac_clk, dac_sdi, dac_cs_n, dac_ld_n}); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (3) begin
      @(negedge clk_X4);
      if (!dac_ld_n) ld_low++;
    end
    rst_n = 1'b1;
    m_ptr = 0;
    n_checks++; if (ld_low != 0) begin n_errors++; $display("FAIL abort_ld got %0d low cycles exp 0", ld_low); end
    r = $urandom_range(0, 1);
    cb = 12'($urandom);
    set_code(r, cb);
    req_valid = 2'(1 << r);
    #1;
    exp_r = model_pick(req_valid, m_ptr);
    n_checks++; if (req_ready !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL abort_regrant got %b exp %b", req_ready, 2'(1 << exp_r)); end
    observe(2'(1 << r), 2'b00, -1, -1, o);
    m_ptr = (exp_r + 1) % NUM_REQ;
    n_checks++; if (o.word !== cb || o.edges != 12) begin n_errors++; $display("FAIL abort_restart got %h/%0d exp %h/12", o.word, o.edges, cb); end
    n_checks++; if (o.ld_low != 4) begin n_errors++; $display("FAIL abort_restart_ld got %0d exp 4", o.ld_low); end
  endtask

  task automatic test_enable_drop();
    obs_t o;
    int bad, exp_r;
    enable = 1'b1;
    set_code(0, 12'($urandom));
    set_code(1, 12'($urandom));
    req_valid = 2'b01;
    #1;
    exp_r = model_pick(2'b01, m_ptr);
    n_checks++; if (req_ready !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL endrop_ready got %b exp %b", req_ready, 2'(1 << exp_r)); end
    observe(2'b01, 2'b10, 11, 11, o);
    m_ptr = (exp_r + 1) % NUM_REQ;
    n_checks++; if (o.word !== codes[0] || o.ld_low != 4 || o.end_off != XFER) begin n_errors++; $display("FAIL endrop_complete got %h ld %0d len %0d exp %h 4 %0d", o.word, o.ld_low, o.end_off, codes[0], XFER); end
    bad = 0;
    repeat (100) begin
      @(negedge clk_X4);
      if (req_ready != 2'b00 || busy) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL endrop_hold got %0d active cycles exp 0", bad); end
    enable = 1'b1;
    #1;
    exp_r = model_pick(2'b10, m_ptr);
    n_checks++; if (req_ready !== 2'(1 << exp_r)) begin n_errors++; $display("FAIL endrop_resume got %b exp %b", req_ready, 2'(1 << exp_r)); end
    observe(2'b10, 2'b00, -1, -1, o);
    m_ptr = (exp_r + 1) % NUM_REQ;
    n_checks++; if (o.gid !== 2'd1 || o.word !== codes[1]) begin n_errors++; $display("FAIL endrop_second got id %0d %h exp 1 %h", o.gid, o.word, codes[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_random();
    test_back_to_back();
    test_abort();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
